video_stream_checker: RTL and testbench
=======================================

# video_stream_checker

Sink-side checker for the native video stream (vsync/hsync/de/data) produced by the test-pattern source. It aligns to frame boundaries, measures active width and height per frame, checks every active pixel against the counting pattern {line index, pixel index}, and reports lock, size errors and a cumulative data-error count. It sits on the receive side of the video path, after the VDMA read-back, for on-board and simulation loopback checks.

## Interface
- DSIZE, 24: pixel width; must be ≥17.
- pclk  in  1  pixel clock; all logic on rising edge.
- prst_n  in  1  asynchronous, active-low reset.
- enable  in  1  checker enable; low returns to SEARCH and clears all state.
- vsync  in  1  frame sync, active high.
- hsync  in  1  line sync, active high; informational only, not used for counting.
- de  in  1  data enable, active high.
- data  in  DSIZE  pixel data.
- exp_hactive  in  16  expected active pixels per line.
- exp_vactive  in  16  expected active lines per frame.
- meas_hactive  out  16  width of the first line of the last completed frame.
- meas_vactive  out  16  active lines in the last completed frame.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_cnt  out  16  completed frames since enable; wraps.
- size_err  out  1  last frame size mismatch or unequal line lengths.
- locked  out  1  last frame was clean.
- data_err_cnt  out  16  pixel mismatches since enable; saturates at 0xFFFF.

## Operation
- Input registers: vsync_d, and de_q = de & ~vsync, delayed to de_qd. vs_rise = vsync & ~vsync_d. de_rise = de_q & ~de_qd. de_fall = ~de_q & de_qd.
- States: SEARCH and RUN.
  - SEARCH: counters held at 0; no checking. On vs_rise, go to RUN. No frame_done on this first edge.
  - RUN: count and check. On each vs_rise, close the frame and stay in RUN.
  - enable low, from any state: go to SEARCH. All outputs and counters clear to 0 on the next edge.
- pix_cnt[15:0]: loads 1 on de_rise; +1 on each further de_q cycle; saturates at 0xFFFF.
- line_cnt[15:0]: +1 on de_fall; saturates. Cleared on vs_rise.
- Line close: on de_fall, or on vs_rise while de_qd=1 (open line is forced closed).
  - The first closed line of a frame stores first_len.
  - Any later line with length ≠ first_len sets len_err.
- Pixel check: on every de_q cycle in RUN, the expected value is {line_cnt[DSIZE-17:0], pix_idx[15:0]}, where pix_idx = 0 for the first pixel of a line (then pix_cnt of the previous cycle).
  - On mismatch: data_err_cnt += 1 (saturating) and frm_err is set.
- Frame close (vs_rise in RUN):
  - meas_hactive ← first_len.
  - meas_vactive ← line_cnt, plus 1 if a line is being forced closed.
  - size_err ← (meas ≠ exp in either axis) | len_err.
  - locked ← ~size_err_next & ~frm_err.
  - frame_cnt += 1; frame_done = 1.
  - len_err, frm_err and first_len are cleared for the new frame.
  - A frame with zero lines yields meas 0/0.
- de while vsync is high is ignored: not counted, not checked.

## Timing
- Reset values: all outputs 0; state SEARCH.
- Latency: frame_done and all frame-close updates are registered on the same pclk edge that samples vsync high after low. They are visible one cycle after the first high sample and held until the next frame close.
- data_err_cnt updates on the edge sampling the bad pixel; visible in the next cycle.
- Asynchronous reset mid-frame: immediate return to reset values. The checker re-aligns on the next vs_rise, so the first partial frame is never reported.
- Coincident vs_rise and de_fall: the line closes once, with no double count.

## Test plan
- Clean frames: exp 4×3; drive 3 frames of 4×3 correct pattern with 2-cycle blanking, plus vsync.
  - After the 2nd vs_rise: frame_done pulse, meas 4/3, size_err 0, locked 1, frame_cnt 1, data_err_cnt 0.
- Corrupt one pixel: set line 1, pixel 2 to 0xFFFFFF.
  - data_err_cnt=1 after that cycle; at frame close locked=0, size_err=0.
  - The next clean frame gives locked=1 and data_err_cnt stays 1.
- Size mismatches:
  - 4-line frame with exp_vactive=3 → meas_vactive=4, size_err=1, locked=0.
  - Line lengths 4,4,5 → size_err=1, meas_hactive=4.
- vsync rises while de is high on line 3 → meas_vactive=3; the truncated line counts as a line.
- Saturation: force 70000 mismatching pixels → data_err_cnt holds 0xFFFF.
- Control and reset:
  - Drop enable for 1 cycle mid-frame → all outputs 0; the next vs_rise gives no frame_done; the following one reports normally.
  - Repeat with prst_n pulsed low asynchronously; same result.

Source files
------------

// File: rtl/video_stream_checker.sv
// rtl/video_stream_checker.sv - sink-side frame alignment, size and counting-pattern checker
module video_stream_checker #(
    parameter int DSIZE = 24
) (
    input  logic             pclk,
    input  logic             prst_n,
    input  logic             enable,
    input  logic             vsync,
    input  logic             hsync,
    input  logic             de,
    input  logic [DSIZE-1:0] data,
    input  logic [15:0]      exp_hactive,
    input  logic [15:0]      exp_vactive,
    output logic [15:0]      meas_hactive,
    output logic [15:0]      meas_vactive,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             size_err,
    output logic             locked,
    output logic [15:0]      data_err_cnt
);
    typedef enum logic {SEARCH = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_nx;

    logic             vsync_d;
    logic             de_qd;
    logic             de_q;
    logic             vs_rise;
    logic             de_rise;
    logic             de_fall;

    logic [15:0]      pix_cnt;
    logic [15:0]      line_cnt;
    logic [15:0]      first_len;
    logic             have_first;
    logic             len_err;
    logic             frm_err;

    logic             run;
    logic             frame_close;
    logic             line_close;
    logic             close_first;
    logic             close_diff;
    logic             pix_bad;
    logic [15:0]      pix_idx;
    logic [15:0]      first_len_now;
    logic [15:0]      lines_now;
    logic             len_err_now;
    logic             size_err_nx;
    logic [DSIZE-1:0] exp_pix;
    logic             unused_hsync;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // hsync is informational; line boundaries come from de alone
    assign unused_hsync = hsync;

    // de during vsync is blanked so it never opens, counts or checks a line
    assign de_q    = de & ~vsync;
    assign vs_rise = vsync & ~vsync_d;
    assign de_rise = de_q & ~de_qd;
    assign de_fall = ~de_q & de_qd;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            vsync_d <= 1'b0;
            de_qd   <= 1'b0;
        end else begin
            vsync_d <= vsync;
            de_qd   <= de_q;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = SEARCH;
        end else if ((state == SEARCH) && vs_rise) begin
            state_nx = RUN;
        end
    end

    assign run         = enable & (state == RUN);
    assign frame_close = run & vs_rise;

    // de_fall also fires when vsync rises over an open line, so a forced
    // close and a normal close are the same single event
    assign line_close  = run & de_fall;
    assign close_first = line_close & ~have_first;
    assign close_diff  = line_close & have_first & (pix_cnt != first_len);

    assign pix_idx = de_rise ? 16'd0 : pix_cnt;
    assign exp_pix = {line_cnt[DSIZE-17:0], pix_idx};
    assign pix_bad = run & de_q & (data != exp_pix);

    // Frame-close view including a line that closes on the same edge
    assign first_len_now = close_first ? pix_cnt : first_len;
    assign len_err_now   = len_err | close_diff;
    assign lines_now     = de_qd ? sat_inc(line_cnt) : line_cnt;
    assign size_err_nx   = (first_len_now != exp_hactive) |
                           (lines_now != exp_vactive) | len_err_now;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            pix_cnt      <= 16'd0;
            line_cnt     <= 16'd0;
            first_len    <= 16'd0;
            have_first   <= 1'b0;
            len_err      <= 1'b0;
            frm_err      <= 1'b0;
            meas_hactive <= 16'd0;
            meas_vactive <= 16'd0;
            frame_done   <= 1'b0;
            frame_cnt    <= 16'd0;
            size_err     <= 1'b0;
            locked       <= 1'b0;
            data_err_cnt <= 16'd0;
        end else if (!run) begin
            pix_cnt    <= 16'd0;
            line_cnt   <= 16'd0;
            first_len  <= 16'd0;
            have_first <= 1'b0;
            len_err    <= 1'b0;
            frm_err    <= 1'b0;
            frame_done <= 1'b0;
            if (!enable) begin
                meas_hactive <= 16'd0;
                meas_vactive <= 16'd0;
                frame_cnt    <= 16'd0;
                size_err     <= 1'b0;
                locked       <= 1'b0;
                data_err_cnt <= 16'd0;
            end
        end else begin
            frame_done <= frame_close;

            if (de_rise) begin
                pix_cnt <= 16'd1;
            end else if (de_q) begin
                pix_cnt <= sat_inc(pix_cnt);
            end

            if (vs_rise) begin
                line_cnt <= 16'd0;
            end else if (de_fall) begin
                line_cnt <= sat_inc(line_cnt);
            end

            if (frame_close) begin
                meas_hactive <= first_len_now;
                meas_vactive <= lines_now;
                size_err     <= size_err_nx;
                locked       <= ~size_err_nx & ~frm_err;
                frame_cnt    <= frame_cnt + 16'd1;
                first_len    <= 16'd0;
                have_first   <= 1'b0;
                len_err      <= 1'b0;
                frm_err      <= 1'b0;
            end else begin
                if (close_first) begin
                    first_len  <= pix_cnt;
                    have_first <= 1'b1;
                end
                if (close_diff) begin
                    len_err <= 1'b1;
                end
                if (pix_bad) begin
                    frm_err <= 1'b1;
                end
            end

            if (pix_bad) begin
                data_err_cnt <= sat_inc(data_err_cnt);
            end
        end
    end
endmodule

// File: tb/tb_video_stream_checker.sv
// tb/tb_video_stream_checker.sv - directed and randomized frames against a line-list reference model
module tb_video_stream_checker;
    logic        pclk;
    logic        prst_n;
    logic        enable;
    logic        vsync;
    logic        hsync;
    logic        de;
    logic [23:0] data;
    logic [15:0] exp_hactive;
    logic [15:0] exp_vactive;
    logic [15:0] meas_hactive;
    logic [15:0] meas_vactive;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        size_err;
    logic        locked;
    logic [15:0] data_err_cnt;

    int checks = 0;
    int errors = 0;

    video_stream_checker #(.DSIZE(24)) dut (
        .pclk         (pclk),
        .prst_n       (prst_n),
        .enable       (enable),
        .vsync        (vsync),
        .hsync        (hsync),
        .de           (de),
        .data         (data),
        .exp_hactive  (exp_hactive),
        .exp_vactive  (exp_vactive),
        .meas_hactive (meas_hactive),
        .meas_vactive (meas_vactive),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .size_err     (size_err),
        .locked       (locked),
        .data_err_cnt (data_err_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: a frame is the list of closed line lengths
    bit          m_run;
    bit          m_prev_vs;
    bit          m_in_line;
    int          m_cur_len;
    int          m_lens[$];
    bit          m_frm_err;
    logic [15:0] e_mh, e_mv, e_fc, e_dec;
    logic        e_fd, e_se, e_lk;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void model_frame_start();
        m_lens.delete();
        m_in_line = 1'b0;
        m_cur_len = 0;
        m_frm_err = 1'b0;
    endfunction

    function automatic void model_clear();
        model_frame_start();
        m_run = 1'b0;
        e_mh  = '0;
        e_mv  = '0;
        e_fc  = '0;
        e_dec = '0;
        e_fd  = 1'b0;
        e_se  = 1'b0;
        e_lk  = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_prev_vs = 1'b0;
    endfunction

    function automatic void model_close();
        bit le;
        le   = 1'b0;
        e_mh = (m_lens.size() > 0) ? 16'(m_lens[0]) : 16'd0;
        e_mv = 16'(m_lens.size());
        foreach (m_lens[i]) if (m_lens[i] != m_lens[0]) le = 1'b1;
        e_se = (e_mh != exp_hactive) || (e_mv != exp_vactive) || le;
        e_lk = !e_se && !m_frm_err;
        e_fc = e_fc + 16'd1;
        e_fd = 1'b1;
    endfunction

    function automatic void model_cycle(input bit en, input bit vs, input bit d, input logic [23:0] dat);
        bit          vr;
        logic [23:0] want;
        vr   = vs && !m_prev_vs;
        e_fd = 1'b0;
        if (!en) begin
            model_clear();
        end else if (!m_run) begin
            if (vr) begin
                m_run = 1'b1;
                model_frame_start();
            end
        end else if (vr) begin
            if (m_in_line) m_lens.push_back(sat16(m_cur_len));
            model_close();
            model_frame_start();
        end else if (d && !vs) begin
            want = {8'(m_lens.size()), 16'(m_in_line ? sat16(m_cur_len) : 0)};
            if (dat !== want) begin
                m_frm_err = 1'b1;
                if (e_dec != 16'hFFFF) e_dec = e_dec + 16'd1;
            end
            m_cur_len = m_in_line ? m_cur_len + 1 : 1;
            m_in_line = 1'b1;
        end else if (m_in_line) begin
            m_lens.push_back(sat16(m_cur_len));
            m_in_line = 1'b0;
        end
        m_prev_vs = vs;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_frame_done"}, {15'd0, frame_done}, {15'd0, e_fd});
        chk({tag, "_meas_h"},     meas_hactive, e_mh);
        chk({tag, "_meas_v"},     meas_vactive, e_mv);
        chk({tag, "_frame_cnt"},  frame_cnt, e_fc);
        chk({tag, "_size_err"},   {15'd0, size_err}, {15'd0, e_se});
        chk({tag, "_locked"},     {15'd0, locked}, {15'd0, e_lk});
        chk({tag, "_data_err"},   data_err_cnt, e_dec);
    endtask

    task automatic step(input bit en, input bit vs, input bit d, input logic [23:0] dat);
        enable = en;
        vsync  = vs;
        de     = d;
        data   = dat;
        hsync  = 1'($urandom_range(0, 1));
        model_cycle(en, vs, d, dat);
        @(posedge pclk);
        @(negedge pclk);
        check_all("cyc");
    endtask

    task automatic reset_pulse();
        enable = 1'b1;
        vsync  = 1'b0;
        de     = 1'b0;
        prst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        #2;
        prst_n = 1'b1;
        model_cycle(1'b1, 1'b0, 1'b0, data);
        @(posedge pclk);
        @(negedge pclk);
        check_all("post_arst");
    endtask

    task automatic send_frame(input int nlines, input int w, input int last_w,
                              input int bad_line, input int bad_pix, input bit trunc,
                              input bit allbad, input int abort_line, input int abort_kind);
        int          nblank;
        int          len;
        logic [23:0] dat;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 24'($urandom));
        nblank = int'($urandom_range(1, 2));
        for (int i = 0; i < nblank; i++) step(1'b1, 1'b0, 1'b0, 24'($urandom));
        for (int l = 0; l < nlines; l++) begin
            if (l == abort_line) begin
                if (abort_kind == 1) step(1'b0, 1'b0, 1'b0, 24'($urandom));
                else reset_pulse();
            end
            len = (l == nlines - 1) ? last_w : w;
            for (int p = 0; p < len; p++) begin
                dat = (allbad || (l == bad_line && p == bad_pix)) ? 24'hFFFFFF : {8'(l), 16'(p)};
                step(1'b1, 1'b0, 1'b1, dat);
            end
            if (!(trunc && l == nlines - 1)) begin
                nblank = int'($urandom_range(1, 3));
                for (int i = 0; i < nblank; i++) step(1'b1, 1'b0, 1'b0, 24'($urandom));
            end
        end
    endtask

    initial begin
        int nl, wd, lw, bl, bp;
        prst_n      = 1'b0;
        enable      = 1'b0;
        vsync       = 1'b0;
        hsync       = 1'b0;
        de          = 1'b0;
        data        = '0;
        exp_hactive = 16'd4;
        exp_vactive = 16'd3;
        model_reset();
        @(negedge pclk);
        check_all("reset");
        chk("reset_locked", {15'd0, locked}, 16'd0);
        prst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 24'd0);

        send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
        send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
        chk("f1_meas_h", meas_hactive, 16'd4);
        chk("f1_meas_v", meas_vactive, 16'd3);
        chk("f1_size_err", {15'd0, size_err}, 16'd0);
        chk("f1_locked", {15'd0, locked}, 16'd1);
        chk("f1_frame_cnt", frame_cnt, 16'd1);
        chk("f1_data_err", data_err_cnt, 16'd0);
        send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
        chk("f2_frame_cnt", frame_cnt, 16'd2);
        send_frame(3, 4, 4, 1, 2, 0, 0, -1, 0);
        chk("bad_pix_err_cnt", data_err_cnt, 16'd1);
        chk("f3_locked", {15'd0, locked}, 16'd1);
        send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
        chk("bad_frame_locked", {15'd0, locked}, 16'd0);
        chk("bad_frame_size_err", {15'd0, size_err}, 16'd0);
        chk("bad_frame_cnt", frame_cnt, 16'd4);
        send_frame(4, 4, 4, -1, -1, 0, 0, -1, 0);
        chk("recover_locked", {15'd0, locked}, 16'd1);
        chk("recover_err_cnt", data_err_cnt, 16'd1);
        send_frame(3, 4, 5, -1, -1, 0, 0, -1, 0);
        chk("tall_meas_v", meas_vactive, 16'd4);
        chk("tall_size_err", {15'd0, size_err}, 16'd1);
        chk("tall_locked", {15'd0, locked}, 16'd0);
        send_frame(3, 4, 2, -1, -1, 1, 0, -1, 0);
        chk("uneven_size_err", {15'd0, size_err}, 16'd1);
        chk("uneven_meas_h", meas_hactive, 16'd4);
        send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
        chk("trunc_meas_v", meas_vactive, 16'd3);
        chk("trunc_frame_cnt", frame_cnt, 16'd8);

        for (int f = 0; f < 8; f++) begin
            nl = int'($urandom_range(0, 4));
            wd = int'($urandom_range(1, 6));
            lw = wd + int'($urandom_range(0, 1));
            bl = int'($urandom_range(0, 5));
            bp = int'($urandom_range(0, 7));
            send_frame(nl, wd, lw, bl, bp, 1'($urandom_range(0, 1)), 0, -1, 0);
        end

        for (int k = 1; k <= 2; k++) begin
            send_frame(3, 4, 4, -1, -1, 0, 0, 1, k);
            chk("abort_frame_cnt", frame_cnt, 16'd0);
            chk("abort_data_err", data_err_cnt, 16'd0);
            chk("abort_meas_v", meas_vactive, 16'd0);
            send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
            chk("realign_frame_cnt", frame_cnt, 16'd0);
            send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
            chk("resume_frame_cnt", frame_cnt, 16'd1);
            chk("resume_locked", {15'd0, locked}, 16'd1);
            chk("resume_meas_h", meas_hactive, 16'd4);
        end

        send_frame(1, 70000, 70000, -1, -1, 0, 1, -1, 0);
        send_frame(3, 4, 4, -1, -1, 0, 0, -1, 0);
        chk("sat_data_err", data_err_cnt, 16'hFFFF);
        chk("sat_meas_h", meas_hactive, 16'hFFFF);
        chk("sat_locked", {15'd0, locked}, 16'd0);
        chk("sat_frame_cnt", frame_cnt, 16'd3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
